// File: rtl/mem_port_arbiter.sv
// Two-port (fetch/data) arbiter onto a single memory port with registered
// memory outputs, alternating priority and a wait-cycle timeout.
module mem_port_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                    clk,
  input  logic                    rstN,
  input  logic                    iReq,
  input  logic [ADDR_WIDTH-1:0]   iAddr,
  output logic                    iGnt,
  output logic                    iValid,
  output logic [DATA_WIDTH-1:0]   iRdata,
  input  logic                    dReq,
  input  logic                    dWe,
  input  logic [ADDR_WIDTH-1:0]   dAddr,
  input  logic [DATA_WIDTH-1:0]   dWdata,
  input  logic [DATA_WIDTH/8-1:0] dBe,
  output logic                    dGnt,
  output logic                    dValid,
  output logic [DATA_WIDTH-1:0]   dRdata,
  output logic                    memReq,
  output logic                    memWe,
  output logic [ADDR_WIDTH-1:0]   memAddr,
  output logic [DATA_WIDTH-1:0]   memWdata,
  output logic [DATA_WIDTH/8-1:0] memBe,
  input  logic                    memAck,
  input  logic [DATA_WIDTH-1:0]   memRdata,
  output logic                    busErr
);

  localparam int unsigned WAIT_W = 9;

  typedef enum logic [1:0] {IDLE, IBUSY, DBUSY} state_t;

  state_t            r_state;
  logic              r_last_d;
  logic [WAIT_W-1:0] r_wait;

  logic w_i_elig;
  logic w_d_elig;
  logic w_pick_d;
  logic w_pick_i;
  logic w_timeout;

  // A requester is blind in its own valid cycle so it can drop req afterwards.
  assign w_i_elig  = iReq & ~iValid;
  assign w_d_elig  = dReq & ~dValid;
  assign w_pick_d  = w_d_elig & (~w_i_elig | ~r_last_d);
  assign w_pick_i  = w_i_elig & ~w_pick_d;
  assign w_timeout = (r_wait == WAIT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_state  <= IDLE;
      r_last_d <= 1'b0;
      r_wait   <= '0;
      iGnt     <= 1'b0;
      dGnt     <= 1'b0;
      iValid   <= 1'b0;
      dValid   <= 1'b0;
      iRdata   <= '0;
      dRdata   <= '0;
      memReq   <= 1'b0;
      memWe    <= 1'b0;
      memAddr  <= '0;
      memWdata <= '0;
      memBe    <= '0;
      busErr   <= 1'b0;
    end else begin
      iGnt   <= 1'b0;
      dGnt   <= 1'b0;
      iValid <= 1'b0;
      dValid <= 1'b0;
      busErr <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_pick_d) begin
            r_state  <= DBUSY;
            r_last_d <= 1'b1;
            r_wait   <= '0;
            dGnt     <= 1'b1;
            memReq   <= 1'b1;
            memWe    <= dWe;
            memAddr  <= dAddr;
            memWdata <= dWdata;
            memBe    <= dBe;
          end else if (w_pick_i) begin
            r_state  <= IBUSY;
            r_last_d <= 1'b0;
            r_wait   <= '0;
            iGnt     <= 1'b1;
            memReq   <= 1'b1;
            memWe    <= 1'b0;
            memAddr  <= iAddr;
            memBe    <= '1;
          end
        end
        IBUSY, DBUSY: begin
          // An ack in the final allowed cycle still completes normally.
          if (memAck || w_timeout) begin
            r_state <= IDLE;
            memReq  <= 1'b0;
            memWe   <= 1'b0;
            busErr  <= ~memAck;
            if (r_state == IBUSY) begin
              iValid <= 1'b1;
              iRdata <= memAck ? memRdata : '0;
            end else begin
              dValid <= 1'b1;
              dRdata <= memAck ? memRdata : '0;
            end
          end else begin
            r_wait <= r_wait + WAIT_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: stimulus queues expected grants/completions, a negedge
// monitor checks them against the DUT; a small memory model drives memAck.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rstN;
  logic        iReq, dReq, dWe;
  logic [31:0] iAddr, dAddr, dWdata;
  logic [3:0]  dBe;
  logic        iGnt, iValid, dGnt, dValid;
  logic [31:0] iRdata, dRdata;
  logic        memReq, memWe, memAck, busErr;
  logic [31:0] memAddr, memWdata, memRdata;
  logic [3:0]  memBe;

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(4)) dut (
    .clk(clk), .rstN(rstN),
    .iReq(iReq), .iAddr(iAddr), .iGnt(iGnt), .iValid(iValid), .iRdata(iRdata),
    .dReq(dReq), .dWe(dWe), .dAddr(dAddr), .dWdata(dWdata), .dBe(dBe),
    .dGnt(dGnt), .dValid(dValid), .dRdata(dRdata),
    .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata),
    .memBe(memBe), .memAck(memAck), .memRdata(memRdata), .busErr(busErr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
    bit          err;
    int          gcyc;
    int          busy;
    bit          aborted;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input bit is_d, input bit we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] be,
                      input logic [31:0] rdata, input bit err, input int gcyc,
                      input int busy, input bit aborted);
    exp_t e;
    e.is_d = is_d; e.we = we; e.addr = addr; e.wdata = wdata; e.be = be;
    e.rdata = rdata; e.err = err; e.gcyc = gcyc; e.busy = busy; e.aborted = aborted;
    exp_q.push_back(e);
  endtask

  // Memory model: ack after mem_waits wait cycles (negative = never).
  int          mem_waits = 0;
  logic [31:0] mem_rdata = '0;
  initial begin
    int cnt;
    cnt = 0;
    memAck = 1'b0;
    memRdata = 32'h0BAD_F00D;
    forever begin
      @(negedge clk);
      if (memReq) begin
        memAck = (cnt == mem_waits);
        cnt++;
      end else begin
        memAck = 1'b0;
        cnt = 0;
      end
      memRdata = memAck ? mem_rdata : 32'h0BAD_F00D;
    end
  end

  // Monitor
  logic        s_we;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_be;
  int          busy_cnt = 0;
  bit          unstable = 1'b0;

  always @(negedge clk) begin
    if (!rstN) begin
      while (exp_q.size() > 0 && exp_q[0].aborted) void'(exp_q.pop_front());
    end else begin
      if (iGnt || dGnt) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_gnt", {62'd0, iGnt, dGnt}, 64'd0);
        end else begin
          chk("gnt_side", {62'd0, iGnt, dGnt}, exp_q[0].is_d ? 64'd1 : 64'd2);
          chk("gnt_cycle", 64'(cyc), 64'(exp_q[0].gcyc));
          chk("mem_we", {63'd0, memWe}, {63'd0, exp_q[0].we});
          chk("mem_addr", {32'd0, memAddr}, {32'd0, exp_q[0].addr});
          chk("mem_be", {60'd0, memBe}, {60'd0, exp_q[0].be});
          if (exp_q[0].is_d) chk("mem_wdata", {32'd0, memWdata}, {32'd0, exp_q[0].wdata});
        end
        s_we = memWe; s_addr = memAddr; s_wdata = memWdata; s_be = memBe;
        busy_cnt = 0;
        unstable = 1'b0;
      end
      if (memReq) begin
        busy_cnt++;
        if (memWe !== s_we || memAddr !== s_addr || memWdata !== s_wdata || memBe !== s_be)
          unstable = 1'b1;
      end
      if (iValid || dValid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", {62'd0, iValid, dValid}, 64'd0);
        end else if (exp_q[0].aborted) begin
          chk("aborted_valid", {62'd0, iValid, dValid}, 64'd0);
          void'(exp_q.pop_front());
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("valid_side", {62'd0, iValid, dValid}, e.is_d ? 64'd1 : 64'd2);
          chk("valid_cycle", 64'(cyc), 64'(e.gcyc + e.busy));
          chk("rdata", {32'd0, e.is_d ? dRdata : iRdata}, {32'd0, e.rdata});
          chk("bus_err", {63'd0, busErr}, {63'd0, e.err});
          chk("busy_cycles", 64'(busy_cnt), 64'(e.busy));
          chk("mem_stable", {63'd0, unstable}, 64'd0);
          chk("memreq_idle", {63'd0, memReq}, 64'd0);
        end
      end else begin
        if (busErr) chk("stray_buserr", {63'd0, busErr}, 64'd0);
      end
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_gnt"}, {62'd0, iGnt, dGnt}, 64'd0);
    chk({tag, "_valid"}, {62'd0, iValid, dValid}, 64'd0);
    chk({tag, "_memreq_we_err"}, {61'd0, memReq, memWe, busErr}, 64'd0);
    chk({tag, "_memaddr"}, {32'd0, memAddr}, 64'd0);
    chk({tag, "_memwdata"}, {32'd0, memWdata}, 64'd0);
    chk({tag, "_membe"}, {60'd0, memBe}, 64'd0);
    chk({tag, "_irdata"}, {32'd0, iRdata}, 64'd0);
    chk({tag, "_drdata"}, {32'd0, dRdata}, 64'd0);
  endtask

  initial begin
    int c;
    rstN = 1'b0;
    iReq = 1'b0; dReq = 1'b0; dWe = 1'b0;
    iAddr = '0; dAddr = '0; dWdata = '0; dBe = '0;
    repeat (3) @(negedge clk);
    #1 chk_zero("reset");
    @(negedge clk);
    rstN = 1'b1;

    // Both requesters held: D, I, D; memWe only on data.
    @(negedge clk);
    c = cyc;
    mem_waits = 0; mem_rdata = 32'h5A5A_0025;
    iReq = 1'b1; iAddr = 32'h300;
    dReq = 1'b1; dWe = 1'b1; dAddr = 32'h200; dWdata = 32'hCAFE_0001; dBe = 4'hF;
    push(1, 1, 32'h200, 32'hCAFE_0001, 4'hF, 32'h5A5A_0025, 0, c + 1, 1, 0);
    push(0, 0, 32'h300, 32'h0,         4'hF, 32'h5A5A_0025, 0, c + 3, 1, 0);
    push(1, 1, 32'h200, 32'hCAFE_0001, 4'hF, 32'h5A5A_0025, 0, c + 5, 1, 0);
    repeat (5) @(negedge clk);
    iReq = 1'b0; dReq = 1'b0;
    repeat (4) @(negedge clk);

    // Single fetch, zero wait states.
    c = cyc;
    mem_waits = 0; mem_rdata = 32'hDEAD_BEEF;
    iReq = 1'b1; iAddr = 32'h100;
    push(0, 0, 32'h100, 32'h0, 4'hF, 32'hDEAD_BEEF, 0, c + 1, 1, 0);
    @(negedge clk);
    iReq = 1'b0;
    repeat (4) @(negedge clk);

    // Store with 3 wait states; req dropped mid-transaction.
    c = cyc;
    mem_waits = 3; mem_rdata = 32'h0000_0026;
    dReq = 1'b1; dWe = 1'b1; dAddr = 32'h2000; dWdata = 32'h1234_5678; dBe = 4'b0011;
    push(1, 1, 32'h2000, 32'h1234_5678, 4'b0011, 32'h0000_0026, 0, c + 1, 4, 0);
    @(negedge clk);
    dReq = 1'b0;
    repeat (6) @(negedge clk);

    // Timeout: memAck never comes.
    c = cyc;
    mem_waits = -1; mem_rdata = 32'hFFFF_FFFF;
    dReq = 1'b1; dWe = 1'b0; dAddr = 32'h3000; dWdata = 32'h0; dBe = 4'hF;
    push(1, 0, 32'h3000, 32'h0, 4'hF, 32'h0, 1, c + 1, 4, 0);
    @(negedge clk);
    dReq = 1'b0;
    repeat (6) @(negedge clk);

    // Fetch req held through its valid cycle: re-grant only two cycles later.
    c = cyc;
    mem_waits = 0; mem_rdata = 32'h0000_0129;
    iReq = 1'b1; iAddr = 32'h140;
    push(0, 0, 32'h140, 32'h0, 4'hF, 32'h0000_0129, 0, c + 1, 1, 0);
    push(0, 0, 32'h140, 32'h0, 4'hF, 32'h0000_0129, 0, c + 4, 1, 0);
    repeat (4) @(negedge clk);
    iReq = 1'b0;
    repeat (4) @(negedge clk);

    // Reset during DBUSY discards the transaction.
    c = cyc;
    mem_waits = -1;
    dReq = 1'b1; dWe = 1'b1; dAddr = 32'h88; dWdata = 32'h77; dBe = 4'h1;
    push(1, 1, 32'h88, 32'h77, 4'h1, 32'h0, 0, c + 1, 0, 1);
    repeat (2) @(negedge clk);
    rstN = 1'b0; dReq = 1'b0;
    #1 chk_zero("midreset");
    repeat (3) @(negedge clk);
    rstN = 1'b1;

    // After reset the data side wins a simultaneous request again.
    @(negedge clk);
    c = cyc;
    mem_waits = 0; mem_rdata = 32'h0000_0028;
    iReq = 1'b1; iAddr = 32'h400;
    dReq = 1'b1; dWe = 1'b0; dAddr = 32'h44; dWdata = 32'h0; dBe = 4'hF;
    push(1, 0, 32'h44, 32'h0, 4'hF, 32'h0000_0028, 0, c + 1, 1, 0);
    @(negedge clk);
    iReq = 1'b0; dReq = 1'b0;
    repeat (5) @(negedge clk);

    chk("drain", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
